// File: rtl/vga_sync_gen.sv
// VGA timing source: free-running column/row counters with registered active-low
// HSync/VSync and blanked colour outputs, all one clock behind the counts.
// Default geometry is 640x480@60 with a 25 MHz pixel clock.
module vga_sync_gen #(
   parameter int c_TOTAL_COLS    = 800,
   parameter int c_TOTAL_ROWS    = 525,
   parameter int c_ACTIVE_COLS   = 640,
   parameter int c_ACTIVE_ROWS   = 480,
   parameter int c_H_FRONT_PORCH = 16,
   parameter int c_H_SYNC_WIDTH  = 96,
   parameter int c_V_FRONT_PORCH = 10,
   parameter int c_V_SYNC_WIDTH  = 2
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic [3:0] i_Red_Video,
   input  logic [3:0] i_Grn_Video,
   input  logic [3:0] i_Blu_Video,
   output logic [9:0] o_Col_Count,
   output logic [9:0] o_Row_Count,
   output logic       o_Active,
   output logic       o_Frame_Start,
   output logic [7:0] o_Frame_Count,
   output logic       o_HSync,
   output logic       o_VSync,
   output logic [3:0] o_Red_Video,
   output logic [3:0] o_Grn_Video,
   output logic [3:0] o_Blu_Video
);

   // Porch geometry must leave room for a back porch; a bad override stops elaboration.
   if (c_H_FRONT_PORCH + c_H_SYNC_WIDTH >= c_TOTAL_COLS - c_ACTIVE_COLS) begin : g_bad_h
      $error("vga_sync_gen: horizontal front porch + sync width exceeds blanking");
   end
   if (c_V_FRONT_PORCH + c_V_SYNC_WIDTH >= c_TOTAL_ROWS - c_ACTIVE_ROWS) begin : g_bad_v
      $error("vga_sync_gen: vertical front porch + sync width exceeds blanking");
   end

   localparam logic [9:0] c_COL_LAST = 10'(c_TOTAL_COLS - 1);
   localparam logic [9:0] c_ROW_LAST = 10'(c_TOTAL_ROWS - 1);
   localparam logic [9:0] c_ACT_COLS = 10'(c_ACTIVE_COLS);
   localparam logic [9:0] c_ACT_ROWS = 10'(c_ACTIVE_ROWS);
   localparam logic [9:0] c_HS_FIRST = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH);
   localparam logic [9:0] c_HS_LAST  = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH - 1);
   localparam logic [9:0] c_VS_FIRST = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH);
   localparam logic [9:0] c_VS_LAST  = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH - 1);

   logic [9:0] r_Col;
   logic [9:0] r_Row;
   logic [7:0] r_Frame_Count;
   logic       r_HSync;
   logic       r_VSync;
   logic [3:0] r_Red;
   logic [3:0] r_Grn;
   logic [3:0] r_Blu;

   logic w_Col_Wrap;
   logic w_Row_Wrap;
   logic w_Active;
   logic w_HSync_Low;
   logic w_VSync_Low;

   // Wraps are detected by compare so counts never reach c_TOTAL_*.
   assign w_Col_Wrap  = (r_Col == c_COL_LAST);
   assign w_Row_Wrap  = (r_Row == c_ROW_LAST);
   assign w_Active    = (r_Col < c_ACT_COLS) && (r_Row < c_ACT_ROWS);
   assign w_HSync_Low = (r_Col >= c_HS_FIRST) && (r_Col <= c_HS_LAST);
   assign w_VSync_Low = (r_Row >= c_VS_FIRST) && (r_Row <= c_VS_LAST);

   // Column/row counters and completed-frame counter; row and frame step on the column wrap.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_Col         <= 10'd0;
         r_Row         <= 10'd0;
         r_Frame_Count <= 8'd0;
      end else if (w_Col_Wrap) begin
         r_Col <= 10'd0;
         if (w_Row_Wrap) begin
            r_Row         <= 10'd0;
            r_Frame_Count <= r_Frame_Count + 8'd1;
         end else begin
            r_Row <= r_Row + 10'd1;
         end
      end else begin
         r_Col <= r_Col + 10'd1;
      end
   end

   // Single output register stage: syncs and blanked colour stay aligned at the pins.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_HSync <= 1'b1;
         r_VSync <= 1'b1;
         r_Red   <= 4'h0;
         r_Grn   <= 4'h0;
         r_Blu   <= 4'h0;
      end else begin
         r_HSync <= ~w_HSync_Low;
         r_VSync <= ~w_VSync_Low;
         r_Red   <= w_Active ? i_Red_Video : 4'h0;
         r_Grn   <= w_Active ? i_Grn_Video : 4'h0;
         r_Blu   <= w_Active ? i_Blu_Video : 4'h0;
      end
   end

   assign o_Col_Count   = r_Col;
   assign o_Row_Count   = r_Row;
   assign o_Active      = w_Active;
   assign o_Frame_Start = (r_Col == 10'd0) && (r_Row == 10'd0);
   assign o_Frame_Count = r_Frame_Count;
   assign o_HSync       = r_HSync;
   assign o_VSync       = r_VSync;
   assign o_Red_Video   = r_Red;
   assign o_Grn_Video   = r_Grn;
   assign o_Blu_Video   = r_Blu;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a reduced-geometry instance for frame-level behaviour
// (table of hand-derived points, scoreboard on registered outputs, reset, 256-frame wrap)
// and a full 640x480 instance for line timing.
module tb_vga_sync_gen;

   // Reduced geometry: 20x12 total, 12x8 active, HSync low cols 14..16, VSync low rows 9..10.
   localparam int TC = 20, TR = 12, AC = 12, AR = 8, HFP = 2, HSW = 3, VFP = 1, VSW = 2;
   localparam int FRAME = TC * TR;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rst_full_n;
   logic [3:0] in_r, in_g, in_b;

   logic [9:0] col, row;
   logic       act, fs, hs, vs;
   logic [7:0] fc;
   logic [3:0] out_r, out_g, out_b;

   logic [9:0] f_col, f_row;
   logic       f_act, f_fs, f_hs, f_vs;
   logic [7:0] f_fc;
   logic [3:0] f_r, f_g, f_b;

   always #5 clk = ~clk;

   vga_sync_gen #(
      .c_TOTAL_COLS(TC), .c_TOTAL_ROWS(TR), .c_ACTIVE_COLS(AC), .c_ACTIVE_ROWS(AR),
      .c_H_FRONT_PORCH(HFP), .c_H_SYNC_WIDTH(HSW), .c_V_FRONT_PORCH(VFP), .c_V_SYNC_WIDTH(VSW)
   ) dut (
      .i_Clk(clk), .i_Rst_L(rst_n),
      .i_Red_Video(in_r), .i_Grn_Video(in_g), .i_Blu_Video(in_b),
      .o_Col_Count(col), .o_Row_Count(row), .o_Active(act), .o_Frame_Start(fs),
      .o_Frame_Count(fc), .o_HSync(hs), .o_VSync(vs),
      .o_Red_Video(out_r), .o_Grn_Video(out_g), .o_Blu_Video(out_b)
   );

   vga_sync_gen dut_full (
      .i_Clk(clk), .i_Rst_L(rst_full_n),
      .i_Red_Video(4'hF), .i_Grn_Video(4'hF), .i_Blu_Video(4'hF),
      .o_Col_Count(f_col), .o_Row_Count(f_row), .o_Active(f_act), .o_Frame_Start(f_fs),
      .o_Frame_Count(f_fc), .o_HSync(f_hs), .o_VSync(f_vs),
      .o_Red_Video(f_r), .o_Grn_Video(f_g), .o_Blu_Video(f_b)
   );

   int vectors    = 0;
   int miscompares = 0;

   task automatic check(input string name, input int actual, input int expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Hand-derived points, n = rising edges since reset release.
   typedef struct {
      int n; int col; int row; bit act; bit fs; bit hs; bit vs; int fc;
   } vec_t;
   vec_t tbl[$];

   // Expected registered outputs, pushed when the matching count is presented.
   typedef struct { bit hs; bit vs; logic [3:0] r; logic [3:0] g; logic [3:0] b; } exp_t;
   exp_t sb[$];

   // Independent reference position.
   int m_col, m_row, m_fc, n, fs_pulses;

   task automatic model_reset();
      exp_t e;
      m_col = 0; m_row = 0; m_fc = 0; n = 0;
      sb.delete();
      e.hs = 1'b1; e.vs = 1'b1; e.r = 4'h0; e.g = 4'h0; e.b = 4'h0;
      sb.push_back(e);
   endtask

   // Called at a negedge: check current outputs, drive next colour, advance to next negedge.
   task automatic step();
      exp_t e;
      bit   m_act;
      m_act = (m_col < AC) && (m_row < AR);
      check("col", int'(col), m_col);
      check("row", int'(row), m_row);
      check("active", int'(act), int'(m_act));
      check("frame_start", int'(fs), int'(m_col == 0 && m_row == 0));
      check("frame_count", int'(fc), m_fc);
      if (fs) fs_pulses++;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         check("hsync", int'(hs), int'(e.hs));
         check("vsync", int'(vs), int'(e.vs));
         check("red", int'(out_r), int'(e.r));
         check("grn", int'(out_g), int'(e.g));
         check("blu", int'(out_b), int'(e.b));
      end
      foreach (tbl[k]) begin
         if (tbl[k].n == n) begin
            check("tbl_col", int'(col), tbl[k].col);
            check("tbl_row", int'(row), tbl[k].row);
            check("tbl_active", int'(act), int'(tbl[k].act));
            check("tbl_fstart", int'(fs), int'(tbl[k].fs));
            check("tbl_hsync", int'(hs), int'(tbl[k].hs));
            check("tbl_vsync", int'(vs), int'(tbl[k].vs));
            check("tbl_fcount", int'(fc), tbl[k].fc);
         end
      end
      in_r = 4'($urandom_range(1, 15));
      in_g = 4'($urandom_range(0, 15));
      in_b = 4'($urandom_range(0, 15));
      e.hs = !(m_col >= AC + HFP && m_col <= AC + HFP + HSW - 1);
      e.vs = !(m_row >= AR + VFP && m_row <= AR + VFP + VSW - 1);
      e.r  = m_act ? in_r : 4'h0;
      e.g  = m_act ? in_g : 4'h0;
      e.b  = m_act ? in_b : 4'h0;
      sb.push_back(e);
      if (m_col == TC - 1) begin
         m_col = 0;
         if (m_row == TR - 1) begin
            m_row = 0;
            m_fc  = (m_fc + 1) % 256;
         end else begin
            m_row++;
         end
      end else begin
         m_col++;
      end
      n++;
      @(negedge clk);
   endtask

   task automatic add(input int tn, input int c, input int r, input bit a, input bit f,
                      input bit h, input bit v, input int fcnt);
      vec_t t;
      t.n = tn; t.col = c; t.row = r; t.act = a; t.fs = f; t.hs = h; t.vs = v; t.fc = fcnt;
      tbl.push_back(t);
   endtask

   initial begin
      int line_len, hs_low, first_low_col;
      bit seen_low;

      add(0,   0,  0, 1, 1, 1, 1, 0);
      add(1,   1,  0, 1, 0, 1, 1, 0);
      add(12, 12,  0, 0, 0, 1, 1, 0);
      add(14, 14,  0, 0, 0, 1, 1, 0);
      add(15, 15,  0, 0, 0, 0, 1, 0);
      add(17, 17,  0, 0, 0, 0, 1, 0);
      add(18, 18,  0, 0, 0, 1, 1, 0);
      add(20,  0,  1, 1, 0, 1, 1, 0);
      add(160, 0,  8, 0, 0, 1, 1, 0);
      add(180, 0,  9, 0, 0, 1, 1, 0);
      add(181, 1,  9, 0, 0, 1, 0, 0);
      add(220, 0, 11, 0, 0, 1, 0, 0);
      add(221, 1, 11, 0, 0, 1, 1, 0);
      add(239, 19, 11, 0, 0, 1, 1, 0);
      add(240, 0,  0, 1, 1, 1, 1, 1);

      // Reset held for 5 clocks with non-zero colour on the inputs.
      rst_n = 1'b0; rst_full_n = 1'b0;
      in_r = 4'hF; in_g = 4'hF; in_b = 4'hF;
      repeat (5) @(negedge clk);
      check("rst_col", int'(col), 0);
      check("rst_row", int'(row), 0);
      check("rst_hsync", int'(hs), 1);
      check("rst_vsync", int'(vs), 1);
      check("rst_video", int'({out_r, out_g, out_b}), 0);
      check("rst_fcount", int'(fc), 0);
      check("rst_active", int'(act), 1);
      check("rst_fstart", int'(fs), 1);

      // Release and run into frame 1 up to (5,3).
      rst_n = 1'b1;
      model_reset();
      while (n < FRAME + 3 * TC + 5) step();

      // Asynchronous reset mid-frame, sampled before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      check("arst_col", int'(col), 0);
      check("arst_row", int'(row), 0);
      check("arst_fcount", int'(fc), 0);
      check("arst_hsync", int'(hs), 1);
      check("arst_vsync", int'(vs), 1);
      check("arst_video", int'({out_r, out_g, out_b}), 0);
      repeat (3) @(negedge clk);

      // Restart from (0,0) and run 256 full frames.
      rst_n = 1'b1;
      model_reset();
      fs_pulses = 0;
      while (n < 256 * FRAME) step();
      check("wrap_fcount", int'(fc), 0);
      check("wrap_col", int'(col), 0);
      check("wrap_row", int'(row), 0);
      check("wrap_fstart_pulses", fs_pulses, 256);

      // Full-size line timing: 800 clocks per line, HSync low 96 clocks starting at (657,0).
      rst_full_n = 1'b1;
      line_len = 0; hs_low = 0; first_low_col = -1; seen_low = 1'b0;
      for (int i = 1; i <= 1700; i++) begin
         @(negedge clk);
         if (!f_hs) begin
            hs_low++;
            if (!seen_low) begin
               seen_low = 1'b1;
               first_low_col = int'(f_col);
            end
         end
         if (f_col == 10'd0) begin
            line_len = i;
            break;
         end
      end
      check("full_line_len", line_len, 800);
      check("full_hsync_low", hs_low, 96);
      check("full_hsync_first_col", first_low_col, 657);
      check("full_row_after_line", int'(f_row), 1);
      check("full_vsync_line0", int'(f_vs), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
